ex_mem_pipe: RTL

- Parametrised EX/MEM pipeline register; successor to the fixed 32-bit EX/MEM latch.
- Carries the register-file write, HI/LO write and multi-cycle carry state (hilo accumulator, cycle count) from EX into MEM.
- Adds a flush input, a valid bit, an explicit RUN/BUBBLE/HOLD stage state, a saturating stall-cycle counter, and a selectable stall-vector index.

---
 rtl/ex_mem_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with flush, valid bit, RUN/BUBBLE/HOLD state and stall counter.
// Optional write-data parity output enabled by defining EX_MEM_PIPE_PARITY_EN.
module ex_mem_pipe #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 2,
  parameter int STALL_IDX   = 3,
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   flush,
  input  logic                   ex_valid,
  input  logic [REG_ADDR_W-1:0]  ex_wd,
  input  logic                   ex_wreg,
  input  logic [DATA_W-1:0]      ex_wdata,
  input  logic [DATA_W-1:0]      ex_hi,
  input  logic [DATA_W-1:0]      ex_lo,
  input  logic                   ex_whilo,
  input  logic [2*DATA_W-1:0]    hilo_i,
  input  logic [CNT_W-1:0]       cnt_i,
  output logic                   mem_valid,
  output logic [REG_ADDR_W-1:0]  mem_wd,
  output logic                   mem_wreg,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [DATA_W-1:0]      mem_hi,
  output logic [DATA_W-1:0]      mem_lo,
  output logic                   mem_whilo,
`ifdef EX_MEM_PIPE_PARITY_EN
  output logic                   mem_wdata_par,
`endif
  output logic [2*DATA_W-1:0]    hilo_o,
  output logic [CNT_W-1:0]       cnt_o,
  output logic [1:0]             stage_state,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    BUBBLE = 2'b01,
    HOLD   = 2'b10
  } state_t;

  localparam logic [STALL_CNT_W-1:0] SC_MAX = {STALL_CNT_W{1'b1}};

  state_t r_state, w_state_nx;

  logic                   w_stall_me, w_stall_nx;
  logic                   r_valid, r_wreg, r_whilo;
  logic [REG_ADDR_W-1:0]  r_wd;
  logic [DATA_W-1:0]      r_wdata, r_hi, r_lo;
  logic [2*DATA_W-1:0]    r_hilo;
  logic [CNT_W-1:0]       r_cnt;
  logic [STALL_CNT_W-1:0] r_sc;

  assign w_stall_me = stall[STALL_IDX];
  assign w_stall_nx = stall[STALL_IDX+1];

  always_comb begin
    w_state_nx = RUN;
    if (flush || !w_stall_me) w_state_nx = RUN;
    else if (w_stall_nx)      w_state_nx = HOLD;
    else                      w_state_nx = BUBBLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_wdata <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_whilo <= 1'b0;
      r_hilo  <= '0;
      r_cnt   <= '0;
      r_sc    <= '0;
    end else if (flush || (w_stall_me && !w_stall_nx)) begin
      r_valid <= 1'b0;
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_wdata <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_whilo <= 1'b0;
      // a squashed slot drops the carry; a bubble keeps it cycling
      r_hilo  <= flush ? '0 : hilo_i;
      r_cnt   <= flush ? '0 : cnt_i;
      r_sc    <= flush ? '0 : ((r_sc == SC_MAX) ? r_sc : r_sc + 1'b1);
    end else if (!w_stall_me) begin
      r_valid <= ex_valid;
      r_wd    <= ex_wd;
      r_wreg  <= ex_wreg;
      r_wdata <= ex_wdata;
      r_hi    <= ex_hi;
      r_lo    <= ex_lo;
      r_whilo <= ex_whilo;
      r_hilo  <= '0;
      r_cnt   <= '0;
      r_sc    <= '0;
    end else begin
      r_hilo  <= hilo_i;
      r_cnt   <= cnt_i;
      r_sc    <= (r_sc == SC_MAX) ? r_sc : r_sc + 1'b1;
    end
  end

`ifdef EX_MEM_PIPE_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_par <= 1'b0;
    else if (flush)                  r_par <= 1'b0;
    else if (!w_stall_me)            r_par <= ^ex_wdata;
    else if (!w_stall_nx)            r_par <= 1'b0;
  end

  assign mem_wdata_par = r_par;
`endif

  assign mem_valid    = r_valid;
  assign mem_wd       = r_wd;
  assign mem_wreg     = r_wreg;
  assign mem_wdata    = r_wdata;
  assign mem_hi       = r_hi;
  assign mem_lo       = r_lo;
  assign mem_whilo    = r_whilo;
  assign hilo_o       = r_hilo;
  assign cnt_o        = r_cnt;
  assign stage_state  = r_state;
  assign stall_cycles = r_sc;

endmodule
